// File: rtl/fpwm_spi_loader.sv
// SPI frame loader for fpwm: shifts a 40-bit {pos, neg, cfg} word out MSB first.
// Optional FPWM_LOADER_SHADOW_EN adds a one-entry shadow so back-to-back frames skip IDLE.
module fpwm_spi_loader #(
  parameter int unsigned HALF_DIV = 10
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic        i_Valid,
  output logic        o_Ready,
  input  logic [15:0] i_Pos,
  input  logic [15:0] i_Neg,
  input  logic [7:0]  i_Cfg,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_SS,
  output logic        o_SCK,
  output logic        o_MOSI
);

  typedef enum logic [2:0] {StIdle, StSetup, StSckHi, StSckLo, StGap} state_e;

  localparam logic [7:0] DivLast = 8'(HALF_DIV - 1);

  state_e      state_q, state_d;
  logic [7:0]  div_cnt_q, div_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [39:0] shift_q, shift_d;
  logic [39:0] in_word;
  logic        accept;
  logic        div_end;
  logic        in_frame;

`ifdef FPWM_LOADER_SHADOW_EN
  logic        shadow_vld_q, shadow_vld_d;
  logic [39:0] shadow_q, shadow_d;
`endif

  assign in_word = {i_Pos, i_Neg, i_Cfg};
  assign div_end = (div_cnt_q == DivLast);

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
`ifdef FPWM_LOADER_SHADOW_EN
    shadow_vld_d = shadow_vld_q;
    shadow_d     = shadow_q;
    o_Ready      = (state_q == StIdle) || !shadow_vld_q;
`else
    o_Ready      = (state_q == StIdle);
`endif
    accept = i_Valid && o_Ready;

    // One free-running half-period counter shared by every non-idle state.
    if (state_q != StIdle) begin
      div_cnt_d = div_end ? 8'd0 : div_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d   = StSetup;
          shift_d   = in_word;
          div_cnt_d = 8'd0;
        end
      end
      StSetup: begin
        if (div_end) begin
          state_d   = StSckHi;
          bit_cnt_d = 6'd39;
        end
      end
      StSckHi: begin
        if (div_end) state_d = StSckLo;
      end
      StSckLo: begin
        if (div_end) begin
          if (bit_cnt_q == 6'd0) begin
            state_d = StGap;
          end else begin
            state_d   = StSckHi;
            bit_cnt_d = bit_cnt_q - 6'd1;
            shift_d   = {shift_q[38:0], 1'b0};
          end
        end
      end
      StGap: begin
        if (div_end) begin
`ifdef FPWM_LOADER_SHADOW_EN
          if (shadow_vld_q) begin
            state_d      = StSetup;
            shift_d      = shadow_q;
            shadow_vld_d = 1'b0;
          end else if (accept) begin
            state_d = StSetup;
            shift_d = in_word;
          end else begin
            state_d = StIdle;
          end
`else
          state_d = StIdle;
`endif
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef FPWM_LOADER_SHADOW_EN
    // A request landing on the last GAP cycle launches directly instead of parking.
    if (accept && (state_q != StIdle) && !((state_q == StGap) && div_end)) begin
      shadow_d     = in_word;
      shadow_vld_d = 1'b1;
    end
`endif
  end

  assign in_frame = (state_q == StSetup) || (state_q == StSckHi) || (state_q == StSckLo);
  assign o_Busy   = (state_q != StIdle);
  assign o_SS     = !in_frame;
  assign o_SCK    = (state_q == StSckHi);
  assign o_MOSI   = in_frame && shift_q[39];
  assign o_Done   = (state_q == StGap) && (div_cnt_q == 8'd0);

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q   <= StIdle;
      div_cnt_q <= 8'd0;
      bit_cnt_q <= 6'd0;
      shift_q   <= 40'd0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

`ifdef FPWM_LOADER_SHADOW_EN
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      shadow_vld_q <= 1'b0;
      shadow_q     <= 40'd0;
    end else begin
      shadow_vld_q <= shadow_vld_d;
      shadow_q     <= shadow_d;
    end
  end
`endif

endmodule
